// File: rtl/game_ctrl_if.sv
// Game sequencer bus: player inputs in, game status and scoring out.
interface game_ctrl_if;
  logic        start;
  logic        collide;
  logic [1:0]  game_state;
  logic        move_tick;
  logic [13:0] score;
  logic [3:0]  level;
  logic [13:0] hi_score;

  // Drives the player inputs and observes the sequencer
  modport master (
    output start,
    output collide,
    input  game_state,
    input  move_tick,
    input  score,
    input  level,
    input  hi_score
  );

  // The sequencer itself
  modport slave (
    input  start,
    input  collide,
    output game_state,
    output move_tick,
    output score,
    output level,
    output hi_score
  );
endinterface

// File: rtl/game_ctrl.sv
// Game sequencer for the jetpack runner: idle / get-ready / play / game-over,
// speed-ramped move tick, score, level and high score.
module game_ctrl #(
  parameter int unsigned PERIOD_W      = 20,
  parameter int unsigned BASE_PERIOD   = 200000,
  parameter int unsigned MIN_PERIOD    = 50000,
  parameter int unsigned STEP          = 10000,
  parameter int unsigned SCORE_DIV     = 8,
  parameter int unsigned PTS_PER_LEVEL = 50,
  parameter int unsigned READY_CYC     = 1000000,
  parameter int unsigned OVER_HOLD     = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  game_ctrl_if.slave  bus
);

  localparam int unsigned SCORE_W   = 14;
  localparam int unsigned LEVEL_W   = 4;
  localparam int unsigned SCORE_MAX = 9999;
  localparam int unsigned LEVEL_MAX = 15;
  localparam int unsigned CD_W      = $clog2(READY_CYC + 1);
  localparam int unsigned HOLD_W    = $clog2(OVER_HOLD + 1);
  localparam int unsigned DIV_W     = $clog2(SCORE_DIV + 1);
  localparam int unsigned PTS_W     = $clog2(PTS_PER_LEVEL + 1);

  // Encoding is the externally visible game_state code
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_OVER  = 2'b10,
    S_READY = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [PERIOD_W-1:0]  cnt_q, cnt_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [PTS_W-1:0]     pts_q, pts_d;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [SCORE_W-1:0]   hi_q, hi_d;
  logic                 tick_q, tick_d;
  logic                 start_prev_q;
  logic                 start_rise_c;

  assign start_rise_c = bus.start & ~start_prev_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      period_q     <= PERIOD_W'(BASE_PERIOD);
      div_q        <= '0;
      pts_q        <= '0;
      cd_q         <= '0;
      hold_q       <= '0;
      score_q      <= '0;
      level_q      <= '0;
      hi_q         <= '0;
      tick_q       <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      div_q        <= div_d;
      pts_q        <= pts_d;
      cd_q         <= cd_d;
      hold_q       <= hold_d;
      score_q      <= score_d;
      level_q      <= level_d;
      hi_q         <= hi_d;
      tick_q       <= tick_d;
      start_prev_q <= bus.start;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    div_d    = div_q;
    pts_d    = pts_q;
    cd_d     = cd_q;
    hold_d   = hold_q;
    score_d  = score_q;
    level_d  = level_q;
    hi_d     = hi_q;
    tick_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_rise_c) begin
          state_d  = S_READY;
          score_d  = '0;
          level_d  = '0;
          cnt_d    = '0;
          div_d    = '0;
          pts_d    = '0;
          period_d = PERIOD_W'(BASE_PERIOD);
          cd_d     = '0;
        end
      end

      S_READY: begin
        if (cd_q == CD_W'(READY_CYC - 1)) begin
          state_d = S_PLAY;
          cnt_d   = '0;
        end else begin
          cd_d = cd_q + CD_W'(1);
        end
      end

      S_PLAY: begin
        if (bus.collide) begin
          // Collision wins over a coincident tick
          state_d = S_OVER;
          hold_d  = '0;
          if (score_q > hi_q) hi_d = score_q;
        end else if (cnt_q == period_q - PERIOD_W'(1)) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (div_q == DIV_W'(SCORE_DIV - 1)) begin
            div_d = '0;
            // Level-ups only happen on a real increment, never while pinned at max
            if (score_q != SCORE_W'(SCORE_MAX)) begin
              score_d = score_q + SCORE_W'(1);
              if (pts_q == PTS_W'(PTS_PER_LEVEL - 1)) begin
                pts_d = '0;
                if (level_q != LEVEL_W'(LEVEL_MAX)) level_d = level_q + LEVEL_W'(1);
                if (period_q >= PERIOD_W'(MIN_PERIOD + STEP))
                  period_d = period_q - PERIOD_W'(STEP);
                else
                  period_d = PERIOD_W'(MIN_PERIOD);
              end else begin
                pts_d = pts_q + PTS_W'(1);
              end
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end

      S_OVER: begin
        if (hold_q == HOLD_W'(OVER_HOLD - 1)) begin
          if (start_rise_c) state_d = S_IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.game_state = state_q;
  assign bus.move_tick  = tick_q;
  assign bus.score      = score_q;
  assign bus.level      = level_q;
  assign bus.hi_score   = hi_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus random start/collide traffic,
// checked every cycle against a score-driven behavioural model.
module tb_game_ctrl;

  localparam int BASE  = 8;
  localparam int MINP  = 4;
  localparam int STEPP = 2;
  localparam int DIV   = 2;
  localparam int PTS   = 3;
  localparam int READY = 5;
  localparam int HOLD  = 6;

  localparam int M_IDLE  = 0;
  localparam int M_READY = 1;
  localparam int M_PLAY  = 2;
  localparam int M_OVER  = 3;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  game_ctrl_if gif ();

  game_ctrl #(
    .PERIOD_W      (20),
    .BASE_PERIOD   (BASE),
    .MIN_PERIOD    (MINP),
    .STEP          (STEPP),
    .SCORE_DIV     (DIV),
    .PTS_PER_LEVEL (PTS),
    .READY_CYC     (READY),
    .OVER_HOLD     (HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (gif.slave)
  );

  always #5 clk = ~clk;

  // Model: phase, cycles in phase, ticks earned this game, best score
  int m_st    = M_IDLE;
  int m_ph    = 0;
  int m_ticks = 0;
  int m_hi    = 0;
  int m_tick  = 0;
  int m_prev  = 0;

  function automatic int m_score();
    return (m_ticks / DIV > 9999) ? 9999 : m_ticks / DIV;
  endfunction

  function automatic int m_level();
    return (m_score() / PTS > 15) ? 15 : m_score() / PTS;
  endfunction

  function automatic int m_period();
    int p;
    p = BASE - m_level() * STEPP;
    return (p < MINP) ? MINP : p;
  endfunction

  function automatic int m_code();
    case (m_st)
      M_READY: return 3;
      M_PLAY:  return 1;
      M_OVER:  return 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic s, input logic c);
    int rise;
    if (r) begin
      m_st = M_IDLE; m_ph = 0; m_ticks = 0; m_hi = 0; m_tick = 0; m_prev = 0;
    end else begin
      rise   = (s && m_prev == 0) ? 1 : 0;
      m_prev = s ? 1 : 0;
      m_tick = 0;
      case (m_st)
        M_IDLE: if (rise != 0) begin m_st = M_READY; m_ph = 0; m_ticks = 0; end
        M_READY: begin
          if (m_ph == READY - 1) begin m_st = M_PLAY; m_ph = 0; end
          else m_ph++;
        end
        M_PLAY: begin
          if (c) begin
            if (m_score() > m_hi) m_hi = m_score();
            m_st = M_OVER; m_ph = 0;
          end else begin
            m_ph++;
            if (m_ph == m_period()) begin m_tick = 1; m_ticks++; m_ph = 0; end
          end
        end
        default: begin
          if (m_ph >= HOLD - 1) begin
            if (rise != 0) m_st = M_IDLE;
          end else m_ph++;
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // One clock: drive inputs, advance, update model, compare every output
  task automatic cyc(input logic r, input logic s, input logic c);
    reset       = r;
    gif.start   = s;
    gif.collide = c;
    @(posedge clk);
    model_step(r, s, c);
    #1;
    chk("game_state", 32'(gif.game_state), 32'(m_code()));
    chk("move_tick",  32'(gif.move_tick),  32'(m_tick));
    chk("score",      32'(gif.score),      32'(m_score()));
    chk("level",      32'(gif.level),      32'(m_level()));
    chk("hi_score",   32'(gif.hi_score),   32'(m_hi));
  endtask

  task automatic play_to_score(input int target, input string tag);
    int g;
    g = 0;
    while (!(m_st == M_PLAY && m_score() >= target) && g < 400) begin
      cyc(1'b0, 1'b0, 1'b0);
      g++;
    end
    if (g >= 400) timeout(tag);
  endtask

  int first_hi;
  int g;

  initial begin
    reset       = 1'b1;
    gif.start   = 1'b0;
    gif.collide = 1'b0;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("rst_state", 32'(gif.game_state), 32'd0);
    chk("rst_hi", 32'(gif.hi_score), 32'd0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // Start sequencing
    cyc(1'b0, 1'b1, 1'b0);
    chk("ready_entry", 32'(gif.game_state), 32'd3);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    chk("ready_hold", 32'(gif.game_state), 32'd3);
    cyc(1'b0, 1'b0, 1'b0);
    chk("play_entry", 32'(gif.game_state), 32'd1);
    repeat (7) cyc(1'b0, 1'b0, 1'b0);
    chk("no_early_tick", 32'(gif.move_tick), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("first_tick", 32'(gif.move_tick), 32'd1);

    // Ramp: 18 ticks land at 8..48 step 8, 54..84 step 6, 88..108 step 4
    repeat (102) cyc(1'b0, 1'b0, 1'b0);
    chk("ramp_level", 32'(gif.level), 32'd3);
    chk("ramp_score", 32'(gif.score), 32'd9);

    // Collision on the cycle a tick would fire
    g = 0;
    while (m_ph + 1 != m_period() && g < 50) begin cyc(1'b0, 1'b0, 1'b0); g++; end
    if (g >= 50) timeout("coll_align");
    first_hi = m_score();
    cyc(1'b0, 1'b0, 1'b1);
    chk("coll_state", 32'(gif.game_state), 32'd2);
    chk("coll_notick", 32'(gif.move_tick), 32'd0);
    chk("coll_score", 32'(gif.score), 32'(first_hi));
    chk("coll_hi", 32'(gif.hi_score), 32'(first_hi));

    // Over hold: early start ignored, later start honoured
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("hold_ignore", 32'(gif.game_state), 32'd2);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("hold_release", 32'(gif.game_state), 32'd0);

    // Lower-scoring second game keeps the high score
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (25) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("hi_kept", 32'(gif.hi_score), 32'(first_hi));
    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Start held high: one game only, no restart after it ends
    cyc(1'b0, 1'b1, 1'b0);
    chk("held_ready", 32'(gif.game_state), 32'd3);
    repeat (30) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (15) cyc(1'b0, 1'b1, 1'b0);
    chk("held_stuck_over", 32'(gif.game_state), 32'd2);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("held_rearm", 32'(gif.game_state), 32'd0);

    // Start held through reset release gives one edge
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("rst_held_start", 32'(gif.game_state), 32'd3);
    cyc(1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 999) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 59) == 0));
    end

    // Reset mid-game after a high score exists
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    play_to_score(2, "wait_score2");
    cyc(1'b0, 1'b0, 1'b1);
    chk("pre_hi", 32'(gif.hi_score), 32'd2);
    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    play_to_score(5, "wait_score5");
    chk("mid_score", 32'(gif.score), 32'd5);
    cyc(1'b1, 1'b0, 1'b0);
    chk("mid_rst_state", 32'(gif.game_state), 32'd0);
    chk("mid_rst_score", 32'(gif.score), 32'd0);
    chk("mid_rst_level", 32'(gif.level), 32'd0);
    chk("mid_rst_hi", 32'(gif.hi_score), 32'd0);
    chk("mid_rst_tick", 32'(gif.move_tick), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the jetpack runner. Owns the game-state FSM consumed by the obstacle generator and renderer: idle, get-ready countdown, play, game-over. While playing it generates a speed-ramped `move_tick` strobe, keeps the score and difficulty level, and latches the high score.

## Interface
Parameters:
- `PERIOD_W`, 20: width of move-tick period counter
- `BASE_PERIOD`, 200000: cycles per move tick at level 0
- `MIN_PERIOD`, 50000: period floor
- `STEP`, 10000: period decrement per level
- `SCORE_DIV`, 8: move ticks per score point
- `PTS_PER_LEVEL`, 50: score points per level
- `READY_CYC`, 1000000: countdown length in cycles
- `OVER_HOLD`, 1000000: minimum cycles in OVER before start is honoured

Ports:
- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-high; clock clk
- `start` in 1: start button, level, already synchronised
- `collide` in 1: player/obstacle collision, level
- `game_state` out 2: 00 IDLE, 11 READY, 01 PLAY, 10 OVER
- `move_tick` out 1: one-cycle strobe, PLAY only
- `score` out 14: current score, saturates at 9999
- `level` out 4: difficulty level, saturates at 15
- `hi_score` out 14: best score since reset

## Operation
- All outputs are registered. Reset values: game_state=00, move_tick=0, score=0, level=0, hi_score=0. Internally: period=BASE_PERIOD, all counters 0, start_prev=0.
- Start edge: `start_rise = start & ~start_prev`. start_prev is registered every cycle. A start held high through reset release yields one edge on the first cycle after reset.
- IDLE: on start_rise -> READY. Clear score, level, tick counter and divider; set period=BASE_PERIOD; load countdown=0.
- READY: countdown increments every cycle. When countdown==READY_CYC-1 -> PLAY and clear the tick counter. start and collide are ignored.
- PLAY:
  - Tick counter cnt increments every cycle.
  - When cnt==period-1: cnt<=0, move_tick<=1, div<=div+1 (wraps at SCORE_DIV).
  - When div==SCORE_DIV-1 at a tick: score<=score+1 (saturating at 9999).
  - If that new score is a nonzero multiple of PTS_PER_LEVEL: level<=level+1 (saturating), and period<=max(period-STEP, MIN_PERIOD) computed without underflow.
  - A new period takes effect from the next counting interval.
- PLAY with collide=1: -> OVER at that edge. collide has priority over a coincident tick: no move_tick, no score or level change. hi_score<=score if score>hi_score. Load hold counter=0.
- OVER: hold counter increments, saturating at OVER_HOLD-1. Once saturated, start_rise -> IDLE. score and level are held for display.
- move_tick is 0 in every state other than PLAY.
- collide outside PLAY is ignored.
- Reset at any point returns every output and internal register to its reset value, including hi_score.

## Timing
- A start_rise sampled at edge E puts game_state=11 after E. game_state becomes 01 exactly READY_CYC cycles later.
- The first move_tick is high in the cycle that begins BASE_PERIOD cycles after game_state becomes 01. Subsequent ticks are spaced by the current period.
- score and level update at the same edge that raises move_tick.
- OVER is visible the cycle after collide is sampled. hi_score updates at the same edge.
- A start_rise that arrives during READY, during PLAY, or during OVER before hold expiry is discarded, not queued.

## Test plan
Small parameters for all scenarios: BASE_PERIOD=8, MIN_PERIOD=4, STEP=2, SCORE_DIV=2, PTS_PER_LEVEL=3, READY_CYC=5, OVER_HOLD=6.
- **Start sequencing:** reset, then pulse start for 1 cycle -> game_state 00 -> 11 next cycle, 11 for exactly 5 cycles, then 01; first move_tick 8 cycles after entering 01.
- **Ramp:** play with collide=0 -> score increments every 2nd tick. At score 3: level=1, tick spacing becomes 6. At score 6: spacing 4. At score 9: spacing stays 4, level=3.
- **Collision priority:** assert collide in the cycle cnt==period-1 -> game_state=10 next cycle, no move_tick, score unchanged, hi_score=score.
- **Over hold:** start pulses 2 cycles after entering OVER are ignored. A start pulse 7 cycles after entering OVER -> IDLE. A second game scoring lower leaves hi_score unchanged.
- **Edge detect:** start held high continuously from IDLE -> exactly one transition to READY; no restart after the game ends until start drops and rises again.
- **Reset mid-game:** reset during PLAY with score=5 -> next cycle game_state=00, score=0, level=0, hi_score=0, move_tick=0.
